cordic_iter_sequencer: RTL and testbench

Iterative CORDIC rotation engine for the DDS path. It time-multiplexes one micro-rotation datapath over ITERATIONS cycles instead of instantiating a pipelined chain of one-step elements. It sequences the shift order k and the angle constant e_k, and wraps the operation in valid/ready handshakes. It sits between the phase accumulator (requester) and the DDS output stage (consumer).

---
 rtl/cordic_pkg.sv | 53 +++++
 rtl/cordic_iter_sequencer_if.sv | 33 +++
 rtl/cordic_micro_rotate.sv | 52 +++++
 rtl/cordic_iter_sequencer.sv | 128 ++++++++++++
 tb/tb_cordic_iter_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC rotation engine.
//   state_e     : sequencer states (IDLE / ROTATE / DONE)
//   DEF_*       : default widths and iteration count
//   k_width()   : width of the shift-order counter for a given iteration count
//   atan_const(): elaboration-time angle constant e_k, 45 deg = 2^(aw-1)
package cordic_pkg;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_VALUE_WIDTH   = 8;
  localparam int DEF_ITERATIONS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic int k_width(input int iters);
    return (iters > 1) ? $clog2(iters) : 1;
  endfunction

  // round(atan(2^-k) / (pi/4) * 2^(aw-1)). atan(1) is exactly pi/4, so k=0 is
  // returned directly; for k>=1 the argument is <= 0.5 and the Taylor series
  // converges well within the fixed term count.
  function automatic int atan_const(input int k, input int aw);
    real t;
    real t2;
    real term;
    real acc;
    real scale;
    if (k == 0) begin
      return 1 << (aw - 1);
    end
    t = 1.0;
    for (int i = 0; i < k; i++) begin
      t = t / 2.0;
    end
    t2   = t * t;
    term = t;
    acc  = 0.0;
    for (int n = 0; n < 40; n++) begin
      if ((n % 2) == 0) acc = acc + term / real'(2 * n + 1);
      else              acc = acc - term / real'(2 * n + 1);
      term = term * t2;
    end
    scale = 1.0;
    for (int i = 0; i < aw - 1; i++) begin
      scale = scale * 2.0;
    end
    return $rtoi(acc / 0.7853981633974483 * scale + 0.5);
  endfunction

endpackage

// File: rtl/cordic_iter_sequencer_if.sv
// Handshake bundle between the phase accumulator (master) and the CORDIC
// engine (slave).
//   start_valid/start_ready   : operand handshake, carries x_in/y_in/z_in
//   result_valid/result_ready : result handshake, carries x_out/y_out/z_res
//   busy                      : engine is rotating or holding a result
interface cordic_iter_sequencer_if
  import cordic_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int VALUE_WIDTH   = DEF_VALUE_WIDTH
);
  logic                        start_valid;
  logic                        start_ready;
  logic signed [VALUE_WIDTH:0]   x_in;
  logic signed [VALUE_WIDTH:0]   y_in;
  logic signed [ADDRESS_WIDTH:0] z_in;
  logic                        result_valid;
  logic                        result_ready;
  logic signed [VALUE_WIDTH:0]   x_out;
  logic signed [VALUE_WIDTH:0]   y_out;
  logic signed [ADDRESS_WIDTH:0] z_res;
  logic                        busy;

  modport master (
    output start_valid, x_in, y_in, z_in, result_ready,
    input  start_ready, result_valid, x_out, y_out, z_res, busy
  );

  modport slave (
    input  start_valid, x_in, y_in, z_in, result_ready,
    output start_ready, result_valid, x_out, y_out, z_res, busy
  );
endinterface

// File: rtl/cordic_micro_rotate.sv
// One combinational CORDIC micro-rotation.
//   i_x, i_y : current vector (signed)
//   i_z      : current residual angle (signed); its sign picks the direction
//   i_k      : shift order for this step
//   i_ek     : angle constant for this step (unsigned magnitude)
//   o_x,o_y,o_z : updated vector and residual, two's complement wrap
module cordic_micro_rotate #(
  parameter int VALUE_WIDTH   = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int K_WIDTH       = 3
) (
  input  logic signed [VALUE_WIDTH:0]   i_x,
  input  logic signed [VALUE_WIDTH:0]   i_y,
  input  logic signed [ADDRESS_WIDTH:0] i_z,
  input  logic        [K_WIDTH-1:0]     i_k,
  input  logic        [ADDRESS_WIDTH:0] i_ek,
  output logic signed [VALUE_WIDTH:0]   o_x,
  output logic signed [VALUE_WIDTH:0]   o_y,
  output logic signed [ADDRESS_WIDTH:0] o_z
);

  logic signed [VALUE_WIDTH:0] w_xs;
  logic signed [VALUE_WIDTH:0] w_ys;
  logic                        w_neg;

  // Log-stage barrel shifter: stage b shifts by 2^b when bit b of k is set.
  always_comb begin
    w_xs = i_x;
    w_ys = i_y;
    for (int b = 0; b < K_WIDTH; b++) begin
      if (i_k[b]) begin
        w_xs = w_xs >>> (1 << b);
        w_ys = w_ys >>> (1 << b);
      end
    end
  end

  assign w_neg = i_z[ADDRESS_WIDTH];

  always_comb begin
    if (w_neg) begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_ek;
    end else begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_ek;
    end
  end

endmodule

// File: rtl/cordic_iter_sequencer.sv
// Iterative CORDIC rotation engine: one micro-rotation datapath reused for
// ITERATIONS cycles per operation, wrapped in valid/ready handshakes.
//   CLK   : system clock, rising edge
//   RESET : asynchronous, active-high; aborts any operation in flight
//   bus   : slave side of cordic_iter_sequencer_if (operands, results, busy)
//
// state     | meaning
// ST_IDLE   | start_ready high, waiting for an operand
// ST_ROTATE | one micro-rotation per cycle, k = 0..ITERATIONS-1
// ST_DONE   | result_valid high, outputs held until result_ready
module cordic_iter_sequencer
  import cordic_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int VALUE_WIDTH   = DEF_VALUE_WIDTH,
  parameter int ITERATIONS    = DEF_ITERATIONS
) (
  input  logic                    CLK,
  input  logic                    RESET,
  cordic_iter_sequencer_if.slave  bus
);

  localparam int KW = k_width(ITERATIONS);
  localparam logic [KW-1:0] K_LAST = KW'(ITERATIONS - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic        [KW-1:0]          r_k;
  logic signed [VALUE_WIDTH:0]   r_x;
  logic signed [VALUE_WIDTH:0]   r_y;
  logic signed [ADDRESS_WIDTH:0] r_z;
  logic signed [VALUE_WIDTH:0]   r_x_out;
  logic signed [VALUE_WIDTH:0]   r_y_out;
  logic signed [ADDRESS_WIDTH:0] r_z_res;

  logic signed [VALUE_WIDTH:0]   w_x_nxt;
  logic signed [VALUE_WIDTH:0]   w_y_nxt;
  logic signed [ADDRESS_WIDTH:0] w_z_nxt;
  logic        [ADDRESS_WIDTH:0] w_ek;

  // Angle table padded to a power of two so any counter value indexes it.
  logic [ADDRESS_WIDTH:0] w_ek_tab [2**KW];

  for (genvar g = 0; g < 2**KW; g++) begin : g_ek_tab
    localparam int EK = (g < ITERATIONS) ? atan_const(g, ADDRESS_WIDTH) : 0;
    assign w_ek_tab[g] = EK[ADDRESS_WIDTH:0];
  end

  assign w_ek = w_ek_tab[r_k];

  cordic_micro_rotate #(
    .VALUE_WIDTH   (VALUE_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .K_WIDTH       (KW)
  ) u_step (
    .i_x  (r_x),
    .i_y  (r_y),
    .i_z  (r_z),
    .i_k  (r_k),
    .i_ek (w_ek),
    .o_x  (w_x_nxt),
    .o_y  (w_y_nxt),
    .o_z  (w_z_nxt)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start_valid)  w_state_nxt = ST_ROTATE;
      ST_ROTATE: if (r_k == K_LAST)    w_state_nxt = ST_DONE;
      ST_DONE:   if (bus.result_ready) w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_k     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_res <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_x <= bus.x_in;
            r_y <= bus.y_in;
            r_z <= bus.z_in;
            r_k <= '0;
          end
        end
        ST_ROTATE: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          if (r_k == K_LAST) begin
            r_k     <= '0;
            r_x_out <= w_x_nxt;
            r_y_out <= w_y_nxt;
            r_z_res <= w_z_nxt;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Reset forces the state to IDLE, so start_ready is gated to stay low
  // while RESET is still asserted.
  assign bus.start_ready  = (r_state == ST_IDLE) && !RESET;
  assign bus.result_valid = (r_state == ST_DONE);
  assign bus.busy         = (r_state == ST_ROTATE) || (r_state == ST_DONE);
  assign bus.x_out        = r_x_out;
  assign bus.y_out        = r_y_out;
  assign bus.z_res        = r_z_res;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
module tb_cordic_iter_sequencer;
  import cordic_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cordic_iter_sequencer_if #(.ADDRESS_WIDTH(8), .VALUE_WIDTH(8)) bus ();

  cordic_iter_sequencer #(
    .ADDRESS_WIDTH (8),
    .VALUE_WIDTH   (8),
    .ITERATIONS    (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int z;
    int ex;
    int ey;
    int ez;
  } vec_t;

  vec_t vecs [5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_operands(input int i);
    bus.x_in = 9'(vecs[i].x);
    bus.y_in = 9'(vecs[i].y);
    bus.z_in = 9'(vecs[i].z);
  endtask

  // Called at posedge+1 while IDLE; returns at posedge+1 after the accept edge.
  task automatic accept_op(input int i);
    load_operands(i);
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.result_valid) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int i);
    check({tag, "_x_out"}, int'(bus.x_out), vecs[i].ex);
    check({tag, "_y_out"}, int'(bus.y_out), vecs[i].ey);
    check({tag, "_z_res"}, int'(bus.z_res), vecs[i].ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rv_seen;
    int acc_n;
    int res_n;
    int last_acc;
    int cyc;
    int overlap;
    bit acc_now;

    //            x_in  y_in  z_in   x_out y_out z_res
    vecs[0] = '{  77,    0,    0,    126,    1,   -1};
    vecs[1] = '{  77,    0,  128,     89,   90,    1};
    vecs[2] = '{  77,    0, -255,      0, -128,    0};
    vecs[3] = '{  77,    0, -128,     87,  -90,    1};
    vecs[4] = '{   0,  100,   64,    -64,  152,   -1};

    rst              = 1'b1;
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b0;
    bus.x_in         = '0;
    bus.y_in         = '0;
    bus.z_in         = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", int'(bus.start_ready), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_x_out", int'(bus.x_out), 0);
    check("rst_z_res", int'(bus.z_res), 0);
    #2 rst = 1'b0;
    #1;
    check("rel_start_ready", int'(bus.start_ready), 1);
    @(posedge clk); #1;

    // Table-driven single operations.
    for (int i = 0; i < 5; i++) begin
      accept_op(i);
      check("op_busy", int'(bus.busy), 1);
      check("op_start_ready", int'(bus.start_ready), 0);
      wait_result(lat);
      check("op_latency", lat, 8);
      check_result("op", i);
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
      check("op_rv_cleared", int'(bus.result_valid), 0);
      check("op_back_idle", int'(bus.start_ready), 1);
    end

    // Backpressure: hold the result for 5 cycles, drop a stray start.
    accept_op(0);
    wait_result(lat);
    check("bp_latency", lat, 8);
    for (int c = 0; c < 5; c++) begin
      check("bp_result_valid", int'(bus.result_valid), 1);
      check("bp_start_ready", int'(bus.start_ready), 0);
      check_result("bp", 0);
      if (c == 2) begin
        load_operands(3);
        bus.start_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
    end
    check_result("bp_end", 0);
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    check("bp_rv_cleared", int'(bus.result_valid), 0);
    check("bp_idle_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    check("bp_dropped_start", int'(bus.busy), 0);
    check("bp_ready_again", int'(bus.start_ready), 1);

    // Reset during ROTATE with k=3.
    accept_op(1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_before", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_result_valid", int'(bus.result_valid), 0);
    check("mid_rst_start_ready", int'(bus.start_ready), 0);
    check("mid_rst_x_out", int'(bus.x_out), 0);
    check("mid_rst_y_out", int'(bus.y_out), 0);
    check("mid_rst_z_res", int'(bus.z_res), 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mid_rel_start_ready", int'(bus.start_ready), 1);
    rv_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.result_valid || bus.busy) rv_seen++;
    end
    check("mid_no_result", rv_seen, 0);

    // Back-to-back: start_valid and result_ready held high for 4 operations.
    acc_n    = 0;
    res_n    = 0;
    last_acc = 0;
    cyc      = 0;
    overlap  = 0;
    load_operands(1);
    bus.start_valid  = 1'b1;
    bus.result_ready = 1'b1;
    while (res_n < 4 && cyc < 80) begin
      acc_now = bus.start_valid && bus.start_ready;
      if (acc_now) begin
        if (acc_n > 0) check("b2b_gap", cyc - last_acc, 10);
        last_acc = cyc;
        acc_n++;
      end
      if (bus.start_ready && bus.result_valid) overlap++;
      if (bus.result_valid) begin
        check_result("b2b", res_n + 1);
        res_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        if (acc_n < 4) load_operands(acc_n + 1);
        else           bus.start_valid = 1'b0;
      end
    end
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b0;
    check("b2b_results", res_n, 4);
    check("b2b_accepts", acc_n, 4);
    check("b2b_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
